nv_nvdla_pdp_core_int8_med1d_seq: RTL and testbench



---
 rtl/nv_nvdla_pdp_core_int8_med1d_seq.sv | 102 ++++++++++
 tb/tb_nv_nvdla_pdp_core_int8_med1d_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_pdp_core_int8_med1d_seq.sv
// -----------------------------------------------------------------------------
// nv_nvdla_pdp_core_int8_med1d_seq
//
// Window sequencer wrapped around the combinational PDP int8 1-D median core.
// Elements arrive one per cycle. Each one is fed to the core together with the
// running accumulator, and the core's result is registered back into the
// accumulator. When a 2- or 3-element window completes, the core result is
// captured in a valid/ready output register. That register feeds the 2-D
// median stage.
//
// Ports:
//   nvdla_core_clk  core clock
//   nvdla_core_rst  synchronous reset, active-high
//   cfg_kernel_3    1: 3-element window, 0: 2-element window (taken at window start)
//   in_pvld/in_prdy/in_pd     element stream (int8 sign-extended to DW bits)
//   core_en/core_a/core_b     drive to the med1d core (enable, accumulator, element)
//   core_med                  med1d core result
//   out_pvld/out_prdy/out_pd  packed window result
//   err_fmt                   sticky: an element was not a valid sign-extended int8
// -----------------------------------------------------------------------------
module nv_nvdla_pdp_core_int8_med1d_seq #(
    parameter int DW = 22
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic          cfg_kernel_3,
    input  logic          in_pvld,
    output logic          in_prdy,
    input  logic [DW-1:0] in_pd,
    output logic          core_en,
    output logic [DW-1:0] core_a,
    output logic [DW-1:0] core_b,
    input  logic [DW-1:0] core_med,
    output logic          out_pvld,
    input  logic          out_prdy,
    output logic [DW-1:0] out_pd,
    output logic          err_fmt
);

    logic [DW-1:0] acc;
    logic [1:0]    cnt;
    logic          k3;

    logic [DW-9:0] pd_hi;
    logic          fmt_ok;
    logic          accept;
    logic          k3_eff;
    logic          win_end;

    // A well-formed element has bits above the int8 byte all equal to its sign.
    // A malformed one keeps only its low byte, zero-extended.
    assign pd_hi  = in_pd[DW-1:8];
    assign fmt_ok = (&pd_hi) | ~(|pd_hi);
    assign core_b = fmt_ok ? in_pd : {{(DW-8){1'b0}}, in_pd[7:0]};

    // The input stalls only while a completed result is held and not taken.
    assign in_prdy = ~out_pvld | out_prdy;
    assign accept  = in_pvld & in_prdy;
    assign core_en = accept;
    assign core_a  = acc;

    // At the first element of a window the latched size is not yet valid,
    // so the live configuration decides.
    assign k3_eff  = (cnt == 2'd0) ? cfg_kernel_3 : k3;
    assign win_end = accept & (((cnt == 2'd1) & ~k3_eff) | (cnt == 2'd2));

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            acc      <= '0;
            cnt      <= 2'd0;
            k3       <= 1'b0;
            out_pvld <= 1'b0;
            out_pd   <= '0;
            err_fmt  <= 1'b0;
        end else begin
            if (accept) begin
                if (cnt == 2'd0) begin
                    k3 <= cfg_kernel_3;
                end
                if (!fmt_ok) begin
                    err_fmt <= 1'b1;
                end
                if (win_end) begin
                    out_pd <= core_med;
                    acc    <= '0;
                    cnt    <= 2'd0;
                end else begin
                    acc <= core_med;
                    cnt <= cnt + 2'd1;
                end
            end
            // A window completing while the old result drains keeps valid high
            // and overwrites the payload in the same cycle.
            if (win_end) begin
                out_pvld <= 1'b1;
            end else if (out_prdy) begin
                out_pvld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nv_nvdla_pdp_core_int8_med1d_seq.sv
module tb_nv_nvdla_pdp_core_int8_med1d_seq;

    localparam int DW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_kernel_3;
    logic          in_pvld;
    logic          in_prdy;
    logic [DW-1:0] in_pd;
    logic          core_en;
    logic [DW-1:0] core_a;
    logic [DW-1:0] core_b;
    logic [DW-1:0] core_med;
    logic          out_pvld;
    logic          out_prdy;
    logic [DW-1:0] out_pd;
    logic          err_fmt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nv_nvdla_pdp_core_int8_med1d_seq #(.DW(DW)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cfg_kernel_3   (cfg_kernel_3),
        .in_pvld        (in_pvld),
        .in_prdy        (in_prdy),
        .in_pd          (in_pd),
        .core_en        (core_en),
        .core_a         (core_a),
        .core_b         (core_b),
        .core_med       (core_med),
        .out_pvld       (out_pvld),
        .out_prdy       (out_prdy),
        .out_pd         (out_pd),
        .err_fmt        (err_fmt)
    );

    // Stand-in for the med1d core, step by step on the accumulator tag.
    // The 3-way LUT word is {2'b01, 2'b00, sign(max,mid,min), min[4:0], mid[4:0], max[4:0]}.
    function automatic logic [21:0] core_fn(input logic [21:0] a, input logic [21:0] b);
        logic signed [7:0] p, q, r, mx, md, mn;
        if (a == 22'd0) return {2'b10, 12'd0, b[7:0]};
        if (a[21:20] == 2'b10) begin
            p = a[7:0]; q = b[7:0];
            if (p < q) return {2'b11, 4'd0, p, q};
            return {2'b11, 4'd0, q, p};
        end
        if (a[21:20] == 2'b11) begin
            p = a[15:8]; q = a[7:0]; r = b[7:0];
            if (r > q)      begin mx = r; md = q; mn = p; end
            else if (r > p) begin mx = q; md = r; mn = p; end
            else            begin mx = q; md = p; mn = r; end
            return {2'b01, 2'b00, mx[7], md[7], mn[7], mn[4:0], md[4:0], mx[4:0]};
        end
        return 22'd0;
    endfunction

    assign core_med = core_en ? core_fn(core_a, core_b) : 22'd0;

    // Reference: expected window word straight from the element bytes.
    function automatic logic [21:0] exp_word(input bit kk3, input logic [7:0] e0,
                                             input logic [7:0] e1, input logic [7:0] e2);
        int v[3];
        int n, t;
        logic [7:0] lo, mi, hi;
        n = kk3 ? 3 : 2;
        v[0] = int'($signed(e0)); v[1] = int'($signed(e1)); v[2] = int'($signed(e2));
        for (int i = 0; i < n; i++)
            for (int j = 0; j + 1 < n - i; j++)
                if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        lo = v[0][7:0];
        mi = v[1][7:0];
        hi = v[n-1][7:0];
        if (!kk3) return {2'b11, 4'd0, lo, hi};
        return {2'b01, 2'b00, hi[7], mi[7], lo[7], lo[4:0], mi[4:0], hi[4:0]};
    endfunction

    function automatic logic [21:0] sext(input logic [7:0] b);
        return {{14{b[7]}}, b};
    endfunction

    // Presents one element for one cycle; only used while in_prdy is known high.
    task automatic step(input bit kk3, input logic [21:0] d);
        cfg_kernel_3 = kk3;
        in_pd = d;
        in_pvld = 1'b1;
        @(posedge clk); #1;
        in_pvld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_pvld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_pvld = 1'b0; in_pd = '0; cfg_kernel_3 = 1'b0; out_prdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (in_prdy !== 1'b1) begin errors++; $display("FAIL reset_in_prdy got=%b exp=1", in_prdy); end
        checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL reset_core_en got=%b exp=0", core_en); end
        checks++; if (core_a !== 22'd0) begin errors++; $display("FAIL reset_core_a got=%h exp=0", core_a); end
        checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL reset_out_pvld got=%b exp=0", out_pvld); end
        checks++; if (out_pd !== 22'd0) begin errors++; $display("FAIL reset_out_pd got=%h exp=0", out_pd); end
        checks++; if (err_fmt !== 1'b0) begin errors++; $display("FAIL reset_err_fmt got=%b exp=0", err_fmt); end
    endtask

    task automatic test_k2_basic();
        out_prdy = 1'b1;
        step(1'b0, 22'd5);
        checks++; if (core_a !== 22'h200005) begin errors++; $display("FAIL k2_acc1 got=%h exp=200005", core_a); end
        checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL k2_early_out got=%b exp=0", out_pvld); end
        step(1'b0, 22'h3FFFFD);
        checks++; if (out_pvld !== 1'b1) begin errors++; $display("FAIL k2_out_pvld got=%b exp=1", out_pvld); end
        checks++; if (out_pd !== 22'h30FD05) begin errors++; $display("FAIL k2_out_pd got=%h exp=30fd05", out_pd); end
        checks++; if (core_a !== 22'd0) begin errors++; $display("FAIL k2_acc_clear got=%h exp=0", core_a); end
        @(posedge clk); #1;
        checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL k2_out_drop got=%b exp=0", out_pvld); end
    endtask

    task automatic test_k2_zero();
        out_prdy = 1'b1;
        step(1'b0, 22'd0);
        checks++; if (core_a !== 22'h200000) begin errors++; $display("FAIL zero_acc1 got=%h exp=200000", core_a); end
        step(1'b0, 22'd0);
        checks++; if (out_pd !== 22'h300000 || out_pvld !== 1'b1) begin
            errors++; $display("FAIL zero_out got=%h/%b exp=300000/1", out_pd, out_pvld); end
        @(posedge clk); #1;
    endtask

    task automatic test_k3();
        out_prdy = 1'b1;
        step(1'b1, 22'd1);
        checks++; if (core_a !== 22'h200001) begin errors++; $display("FAIL k3_acc1 got=%h exp=200001", core_a); end
        step(1'b0, 22'd3); // mid-window config change must be ignored
        checks++; if (core_a !== 22'h300103) begin errors++; $display("FAIL k3_acc2 got=%h exp=300103", core_a); end
        checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL k3_early_out got=%b exp=0", out_pvld); end
        step(1'b0, 22'd2);
        checks++; if (out_pvld !== 1'b1) begin errors++; $display("FAIL k3_out_pvld got=%b exp=1", out_pvld); end
        checks++; if (out_pd[14:0] !== 15'h443) begin errors++; $display("FAIL k3_fields got=%h exp=443", out_pd[14:0]); end
        checks++; if (out_pd[21:15] !== 7'b0100000) begin errors++; $display("FAIL k3_lut got=%b exp=0100000", out_pd[21:15]); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [21:0] w1, w2;
        w1 = exp_word(1'b0, 8'd7, 8'd8, 8'd0);
        w2 = exp_word(1'b0, 8'd9, 8'd1, 8'd0);
        out_prdy = 1'b0;
        step(1'b0, 22'd7);
        step(1'b0, 22'd8);
        checks++; if (out_pvld !== 1'b1 || out_pd !== w1) begin
            errors++; $display("FAIL bp_first got=%h/%b exp=%h/1", out_pd, out_pvld, w1); end
        checks++; if (in_prdy !== 1'b0) begin errors++; $display("FAIL bp_in_prdy_drop got=%b exp=0", in_prdy); end
        in_pvld = 1'b1; in_pd = 22'd9;
        #1;
        checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL bp_core_en got=%b exp=0", core_en); end
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (in_prdy !== 1'b0 || out_pd !== w1 || core_a !== 22'd0) begin
                errors++; $display("FAIL bp_hold got=%b/%h/%h exp=0/%h/0", in_prdy, out_pd, core_a, w1); end
        end
        out_prdy = 1'b1;
        #1;
        checks++; if (in_prdy !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", in_prdy); end
        @(posedge clk); #1;
        checks++; if (out_pvld !== 1'b0 || core_a !== 22'h200009) begin
            errors++; $display("FAIL bp_resume got=%b/%h exp=0/200009", out_pvld, core_a); end
        in_pd = 22'd1;
        @(posedge clk); #1;
        in_pvld = 1'b0;
        checks++; if (out_pvld !== 1'b1 || out_pd !== w2) begin
            errors++; $display("FAIL bp_second got=%h/%b exp=%h/1", out_pd, out_pvld, w2); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [21:0] w;
        w = exp_word(1'b1, 8'd10, 8'd20, 8'd30);
        out_prdy = 1'b1;
        step(1'b1, 22'd4);
        step(1'b1, sext(8'hF9));
        do_reset();
        checks++; if (core_a !== 22'd0 || out_pvld !== 1'b0 || in_prdy !== 1'b1) begin
            errors++; $display("FAIL rstmid_state got=%h/%b/%b exp=0/0/1", core_a, out_pvld, in_prdy); end
        step(1'b1, 22'd10);
        checks++; if (core_a !== 22'h20000A || out_pvld !== 1'b0) begin
            errors++; $display("FAIL rstmid_e0 got=%h/%b exp=20000a/0", core_a, out_pvld); end
        step(1'b1, 22'd20);
        checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL rstmid_early got=%b exp=0", out_pvld); end
        step(1'b1, 22'd30);
        checks++; if (out_pvld !== 1'b1 || out_pd !== w) begin
            errors++; $display("FAIL rstmid_out got=%h/%b exp=%h/1", out_pd, out_pvld, w); end
        @(posedge clk); #1;
        checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL rstmid_single got=%b exp=0", out_pvld); end
    endtask

    task automatic test_random();
        logic [21:0] exp_q[$];
        logic [21:0] pend, e;
        logic [7:0]  win[3];
        bit          have, wk3;
        int          wn, outs, wins;
        have = 0; wn = 0; wk3 = 0; outs = 0; wins = 0; pend = '0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (!have && cyc < 400 && $urandom_range(0, 3) != 0) begin
                pend = sext(8'($urandom));
                have = 1;
            end
            in_pvld = have;
            in_pd = have ? pend : 22'd0;
            cfg_kernel_3 = 1'($urandom);
            out_prdy = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            if (out_pvld && out_prdy) begin
                outs++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra got=%h exp=none", out_pd);
                end else begin
                    e = exp_q.pop_front();
                    if (out_pd !== e) begin errors++; $display("FAIL rand_out got=%h exp=%h", out_pd, e); end
                end
            end
            if (in_pvld && in_prdy) begin
                if (wn == 0) wk3 = cfg_kernel_3;
                win[wn] = pend[7:0];
                wn++;
                if (wn == (wk3 ? 3 : 2)) begin
                    exp_q.push_back(exp_word(wk3, win[0], win[1], win[2 % wn]));
                    wins++;
                    wn = 0;
                end
                have = 0;
            end
            @(posedge clk); #1;
        end
        in_pvld = 1'b0;
        checks++; if (exp_q.size() != 0 || outs != wins || wins < 20) begin
            errors++; $display("FAIL rand_count got=%0d outs exp=%0d (left %0d)", outs, wins, exp_q.size()); end
        do_reset();
    endtask

    task automatic test_fmt();
        out_prdy = 1'b1;
        checks++; if (err_fmt !== 1'b0) begin errors++; $display("FAIL fmt_pre got=%b exp=0", err_fmt); end
        step(1'b0, 22'h00F105);
        checks++; if (err_fmt !== 1'b1) begin errors++; $display("FAIL fmt_set got=%b exp=1", err_fmt); end
        checks++; if (core_a !== 22'h200005) begin errors++; $display("FAIL fmt_sanitize got=%h exp=200005", core_a); end
        step(1'b0, 22'd2);
        checks++; if (out_pd !== 22'h300205 || err_fmt !== 1'b1) begin
            errors++; $display("FAIL fmt_out got=%h/%b exp=300205/1", out_pd, err_fmt); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (err_fmt !== 1'b1) begin errors++; $display("FAIL fmt_sticky got=%b exp=1", err_fmt); end
        do_reset();
        checks++; if (err_fmt !== 1'b0) begin errors++; $display("FAIL fmt_clear got=%b exp=0", err_fmt); end
    endtask

    initial begin
        test_reset();
        test_k2_basic();
        test_k2_zero();
        test_k3();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_fmt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
